// File: rtl/tmds_pkg.sv
// Shared definitions for the TMDS receive path: word width, the four
// control-token codes and the alignment FSM state encoding.
package tmds_pkg;

    localparam int TMDS_W = 10;

    // Control tokens, indexed by {C1,C0}
    localparam logic [TMDS_W-1:0] TOK_C00 = 10'h354;
    localparam logic [TMDS_W-1:0] TOK_C01 = 10'h0AB;
    localparam logic [TMDS_W-1:0] TOK_C10 = 10'h154;
    localparam logic [TMDS_W-1:0] TOK_C11 = 10'h2AB;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOCKED = 2'd2
    } tmds_state_t;

endpackage

// File: rtl/tmds_word_decode.sv
// Combinational TMDS 10b -> 8b symbol decoder. Control tokens are reported
// with is_token=1 and their {C1,C0}; all other words are treated as video
// data and undone through the XOR/XNOR chain.
module tmds_word_decode
    import tmds_pkg::*;
(
    input  logic [TMDS_W-1:0] word,
    output logic              is_token,
    output logic [1:0]        ctrl,
    output logic [7:0]        data
);

    logic [7:0] d;

    // Token match first; otherwise undo the optional inversion then the transition chain
    always_comb begin
        d        = word[9] ? ~word[7:0] : word[7:0];
        is_token = 1'b1;
        ctrl     = 2'b00;
        data     = 8'h00;
        case (word)
            TOK_C00: ctrl = 2'b00;
            TOK_C01: ctrl = 2'b01;
            TOK_C10: ctrl = 2'b10;
            TOK_C11: ctrl = 2'b11;
            default: begin
                is_token = 1'b0;
                data[0]  = d[0];
                for (int i = 1; i < 8; i++) begin
                    data[i] = word[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
                end
            end
        endcase
    end

endmodule

// File: rtl/tmds_decoder.sv
// Single-channel TMDS receiver: bit-slip word alignment driven by runs of
// control tokens, followed by symbol decode to pixel byte / DE / control.
// Optional lock-loss event counter enabled by TMDS_DECODER_LOSSCNT_EN;
// without it loss_count is constant zero.
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_TOKENS   = 8,
    parameter int SEARCH_WINDOW = 1024,
    parameter int LOSS_TIMEOUT  = 4096
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [TMDS_W-1:0] raw_in,
    output logic [7:0]        data,
    output logic              de,
    output logic [1:0]        ctrl,
    output logic              locked,
    output logic [3:0]        offset,
    output logic [7:0]        loss_count
);

    localparam int TIMER_SPAN = (SEARCH_WINDOW > LOSS_TIMEOUT) ? SEARCH_WINDOW : LOSS_TIMEOUT;
    localparam int TIMER_W    = $clog2(TIMER_SPAN);
    localparam int TOK_W      = $clog2(LOCK_TOKENS + 1);

    localparam logic [TIMER_W-1:0] SEARCH_LAST = TIMER_W'(SEARCH_WINDOW - 1);
    localparam logic [TIMER_W-1:0] LOSS_LAST   = TIMER_W'(LOSS_TIMEOUT - 1);
    localparam logic [TOK_W-1:0]   TOK_LAST    = TOK_W'(LOCK_TOKENS - 1);
    localparam logic [TOK_W-1:0]   TOK_FULL    = TOK_W'(LOCK_TOKENS);

    logic [TMDS_W-1:0] raw_prev;
    logic [TMDS_W-1:0] win;
    logic [TMDS_W-1:0] win_next;

    logic              dec_tok;
    logic [1:0]        dec_ctrl;
    logic [7:0]        dec_data;

    tmds_state_t       state;
    logic [TIMER_W-1:0] timer;
    logic [TOK_W-1:0]  tok_run;
    logic [TOK_W-1:0]  tok_inc;
    logic              run_hit;

    // Older word sits in the low half because bit 0 is the first serial bit
    assign win_next = TMDS_W'({raw_in, raw_prev} >> offset);

    // Stage 1: keep the previous word and capture the aligned window
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            raw_prev <= '0;
            win      <= '0;
        end else begin
            raw_prev <= raw_in;
            win      <= win_next;
        end
    end

    tmds_word_decode u_word_decode (
        .word     (win),
        .is_token (dec_tok),
        .ctrl     (dec_ctrl),
        .data     (dec_data)
    );

    // Token run length: saturates at LOCK_TOKENS, so a lock hit fires once per run
    assign tok_inc = !dec_tok ? '0 : ((tok_run == TOK_FULL) ? tok_run : tok_run + 1'b1);
    assign run_hit = dec_tok && (tok_run == TOK_LAST);

    // Alignment FSM: dwell at each offset, slip on window expiry, drop lock on silence
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_SEARCH;
            timer   <= '0;
            tok_run <= '0;
            offset  <= 4'd0;
            locked  <= 1'b0;
        end else begin
            case (state)
                ST_SEARCH: begin
                    if (run_hit) begin
                        state   <= ST_LOCKED;
                        locked  <= 1'b1;
                        timer   <= '0;
                        tok_run <= tok_inc;
                    end else if (timer == SEARCH_LAST) begin
                        state   <= ST_SETTLE;
                        offset  <= (offset == 4'd9) ? 4'd0 : offset + 4'd1;
                        timer   <= '0;
                        tok_run <= '0;
                    end else begin
                        timer   <= timer + 1'b1;
                        tok_run <= tok_inc;
                    end
                end
                ST_SETTLE: begin
                    // win still holds a word sliced at the old offset this cycle
                    state   <= ST_SEARCH;
                    tok_run <= '0;
                end
                ST_LOCKED: begin
                    if (run_hit) begin
                        timer   <= '0;
                        tok_run <= tok_inc;
                    end else if (timer == LOSS_LAST) begin
                        state   <= ST_SEARCH;
                        locked  <= 1'b0;
                        timer   <= '0;
                        tok_run <= '0;
                    end else begin
                        timer   <= timer + 1'b1;
                        tok_run <= tok_inc;
                    end
                end
                default: begin
                    state   <= ST_SEARCH;
                    locked  <= 1'b0;
                    timer   <= '0;
                    tok_run <= '0;
                end
            endcase
        end
    end

    // Stage 2: register decoded symbol; outputs stay quiet until aligned
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data <= 8'h00;
            de   <= 1'b0;
            ctrl <= 2'b00;
        end else if (!locked) begin
            data <= 8'h00;
            de   <= 1'b0;
            ctrl <= 2'b00;
        end else if (dec_tok) begin
            data <= 8'h00;
            de   <= 1'b0;
            ctrl <= dec_ctrl;
        end else begin
            data <= dec_data;
            de   <= 1'b1;
        end
    end

`ifdef TMDS_DECODER_LOSSCNT_EN
    logic loss_evt;

    assign loss_evt = (state == ST_LOCKED) && !run_hit && (timer == LOSS_LAST);

    // Count LOCKED->SEARCH transitions, saturating
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            loss_count <= 8'd0;
        end else if (loss_evt && (loss_count != 8'hFF)) begin
            loss_count <= loss_count + 8'd1;
        end
    end
`else
    assign loss_count = 8'd0;
`endif

endmodule
